// File: rtl/booth_pp_accumulator_if.sv
// Handshake/data bundle between a radix-4 Booth encoder and booth_pp_accumulator.
// Optional sticky output is present only when PP_ACC_STICKY_EN is defined.
interface booth_pp_accumulator_if #(
  parameter int N      = 24,
  parameter int NUM_PP = (N / 2) + 1
);
  logic           i_valid;
  logic           o_ready;
  logic [N+1:0]   i_pp [0:NUM_PP-1];
  logic [1:0]     i_cz [0:NUM_PP-2];
  logic           o_valid;
  logic           i_ready;
  logic [2*N-1:0] o_product;
`ifdef PP_ACC_STICKY_EN
  logic           o_sticky;

  modport master (
    output i_valid, i_pp, i_cz, i_ready,
    input  o_ready, o_valid, o_product, o_sticky
  );

  modport slave (
    input  i_valid, i_pp, i_cz, i_ready,
    output o_ready, o_valid, o_product, o_sticky
  );
`else
  modport master (
    output i_valid, i_pp, i_cz, i_ready,
    input  o_ready, o_valid, o_product
  );

  modport slave (
    input  i_valid, i_pp, i_cz, i_ready,
    output o_ready, o_valid, o_product
  );
`endif
endinterface

// File: rtl/booth_pp_accumulator.sv
// Sequential accumulator for radix-4 Booth partial products.
// Captures a full partial-product set, adds one weighted term per cycle
// into a 2N-bit accumulator, then presents the product until accepted.
// Optional macro PP_ACC_STICKY_EN adds o_sticky = OR of o_product[N-2:0].
module booth_pp_accumulator #(
  parameter int N      = 24,
  parameter int NUM_PP = (N / 2) + 1
) (
  input logic                   i_clk,
  input logic                   i_rst,
  booth_pp_accumulator_if.slave bus
);

  localparam int KW = (NUM_PP > 1) ? $clog2(NUM_PP) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NUM_PP - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t         state_q;
  state_t         state_d;

  logic [N+1:0]   pp_q [0:NUM_PP-1];
  // One extra slot kept at zero so the last partial product has no correction.
  logic [1:0]     cz_q [0:NUM_PP-1];
  logic [2*N-1:0] acc_q;
  logic [2*N-1:0] acc_d;
  logic [KW-1:0]  k_q;

  logic [N+1:0]   pp_sel;
  logic [1:0]     cz_sel;
  logic [2*N-1:0] term;
  logic           accept;

  assign accept = (state_q == IDLE) && bus.i_valid;

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; the last partial product moves ACCUM to DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.i_valid) state_d = ACCUM;
      ACCUM:   if (k_q == K_LAST) state_d = DONE;
      DONE:    if (bus.i_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from registered state only.
  always_comb begin
    bus.o_ready = (state_q == IDLE);
    bus.o_valid = (state_q == DONE);
  end

  // Select the current partial product and its correction constant.
  always_comb begin
    pp_sel = '0;
    cz_sel = '0;
    for (int unsigned i = 0; i < NUM_PP; i++) begin
      if (k_q == KW'(i)) begin
        pp_sel = pp_q[i];
        cz_sel = cz_q[i];
      end
    end
  end

  // Weighted term: sign-extended pp plus unsigned correction, at weight 4^k.
  always_comb begin
    term  = ({{(N-2){pp_sel[N+1]}}, pp_sel} + {{(2*N-2){1'b0}}, cz_sel})
            << {k_q, 1'b0};
    acc_d = acc_q + term;
  end

  // Capture registers, accumulator and index counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < NUM_PP; i++) begin
        pp_q[i] <= '0;
        cz_q[i] <= '0;
      end
      acc_q <= '0;
      k_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            for (int unsigned i = 0; i < NUM_PP; i++) begin
              pp_q[i] <= bus.i_pp[i];
            end
            for (int unsigned i = 0; i + 1 < NUM_PP; i++) begin
              cz_q[i] <= bus.i_cz[i];
            end
            cz_q[NUM_PP-1] <= '0;
            acc_q <= '0;
            k_q   <= '0;
          end
        end
        ACCUM: begin
          acc_q <= acc_d;
          if (k_q != K_LAST) begin
            k_q <= k_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_product = acc_q;

`ifdef PP_ACC_STICKY_EN
  logic sticky_q;

  // Sticky tracks the low product bits as each term lands.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sticky_q <= 1'b0;
    end else if (accept) begin
      sticky_q <= 1'b0;
    end else if (state_q == ACCUM) begin
      sticky_q <= |acc_d[N-2:0];
    end
  end

  assign bus.o_sticky = sticky_q;
`endif

endmodule

// File: tb/tb_booth_pp_accumulator.sv
// Self-checking bench for booth_pp_accumulator: directed A*B operations
// encoded with a radix-4 Booth encoder, checked against plain A*B.
module tb_booth_pp_accumulator;

  localparam int N      = 24;
  localparam int NUM_PP = (N / 2) + 1;
  localparam int TMO    = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  booth_pp_accumulator_if #(.N(N), .NUM_PP(NUM_PP)) bus ();

  booth_pp_accumulator #(.N(N), .NUM_PP(NUM_PP)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [N-1:0] cur_a = '0;
  logic [N-1:0] cur_b = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Radix-4 Booth encoding of unsigned B times A.
  // mode 0: negative digits as one's complement with correction 1.
  // mode 1: every non-final product lowered by 2 with correction 2.
  task automatic drive_set(input logic [N-1:0] a, input logic [N-1:0] b, input int mode);
    logic [N+1:0] bx;
    logic [N+1:0] ppv;
    logic [1:0]   czv;
    longint       v;
    int           d;
    int           lo;
    bx = {2'b00, b};
    for (int i = 0; i < NUM_PP; i++) begin
      lo = 0;
      if (i > 0) lo = int'(bx[2*i-1]);
      d   = int'(bx[2*i]) + lo - 2 * int'(bx[2*i+1]);
      czv = 2'd0;
      if (mode == 0) begin
        v   = longint'((d < 0) ? -d : d) * longint'(a);
        ppv = v[N+1:0];
        if (d < 0) begin
          ppv = ~ppv;
          czv = 2'd1;
        end
      end else begin
        if (i < NUM_PP - 1) czv = 2'd2;
        v   = longint'(d) * longint'(a) - longint'(czv);
        ppv = v[N+1:0];
      end
      bus.i_pp[i] = ppv;
      if (i < NUM_PP - 1) bus.i_cz[i] = czv;
    end
    cur_a = a;
    cur_b = b;
  endtask

  // Reference model: an accepted set yields A*B after NUM_PP cycles,
  // held until the downstream accepts it.
  logic           m_ready;
  logic           m_valid;
  int             m_left;
  logic [2*N-1:0] m_prod;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ready <= 1'b1;
      m_valid <= 1'b0;
      m_left  <= 0;
      m_prod  <= '0;
    end else if (m_ready) begin
      if (bus.i_valid) begin
        m_ready <= 1'b0;
        m_left  <= NUM_PP;
        m_prod  <= {{N{1'b0}}, cur_a} * {{N{1'b0}}, cur_b};
      end
    end else if (!m_valid) begin
      if (m_left == 1) m_valid <= 1'b1;
      m_left <= m_left - 1;
    end else if (bus.i_ready) begin
      m_valid <= 1'b0;
      m_ready <= 1'b1;
    end
  end

  // Per-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      chk("cmp_ready", bus.o_ready, m_ready);
      chk("cmp_valid", bus.o_valid, m_valid);
      if (m_valid) begin
        chk("cmp_product", bus.o_product, m_prod);
`ifdef PP_ACC_STICKY_EN
        chk("cmp_sticky", bus.o_sticky, |m_prod[N-2:0]);
`endif
      end
    end
  end

  // One full operation, entered and left on a falling edge.
  task automatic run_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                        input int mode, input int hold, input bit junk,
                        input bit use_lit, input logic [2*N-1:0] lit);
    int             lat;
    bit             seen;
    logic [2*N-1:0] exp;
    exp = use_lit ? lit : {{N{1'b0}}, a} * {{N{1'b0}}, b};
    drive_set(a, b, mode);
    bus.i_valid = 1'b1;
    bus.i_ready = (hold == 0);
    chk({tag, "_ready_at_offer"}, bus.o_ready, 1);
    @(posedge clk);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < TMO) begin
      @(negedge clk);
      if (bus.o_valid) begin
        seen = 1'b1;
      end else begin
        if (junk) drive_set(a ^ 24'h5A5A5A, b ^ N'(lat * 37), mode);
        else bus.i_valid = 1'b0;
        @(posedge clk);
        lat++;
      end
    end
    if (!seen) @(negedge clk);
    chk({tag, "_latency"}, lat, NUM_PP);
    chk({tag, "_product"}, bus.o_product, exp);
`ifdef PP_ACC_STICKY_EN
    chk({tag, "_sticky"}, bus.o_sticky, |exp[N-2:0]);
`endif
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_hold_valid"}, bus.o_valid, 1);
      chk({tag, "_hold_product"}, bus.o_product, exp);
    end
    bus.i_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_after_valid"}, bus.o_valid, 0);
    chk({tag, "_after_ready"}, bus.o_ready, 1);
    bus.i_valid = 1'b0;
  endtask

  initial begin
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    for (int i = 0; i < NUM_PP; i++) bus.i_pp[i] = '0;
    for (int i = 0; i < NUM_PP - 1; i++) bus.i_cz[i] = '0;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", bus.o_ready, 1);
    chk("rst_valid", bus.o_valid, 0);
    chk("rst_product", bus.o_product, 0);
`ifdef PP_ACC_STICKY_EN
    chk("rst_sticky", bus.o_sticky, 0);
`endif
    @(negedge clk);
    rst = 1'b0;

    run_op("max",    24'hFFFFFF, 24'hFFFFFF, 0, 0, 1'b0, 1'b1, 48'hFFFF_FE00_0001);
    run_op("pow2",   24'h800000, 24'h800000, 1, 0, 1'b0, 1'b1, 48'h4000_0000_0000);
    run_op("small",  24'h000003, 24'h000001, 0, 0, 1'b0, 1'b1, 48'h0000_0000_0003);
    run_op("stall",  24'h123456, 24'h00ABCD, 0, 5, 1'b0, 1'b1, 48'h000C_3789_5ADE);

    // Reset while the seventh term (k=6) is pending.
    drive_set(24'h00F00F, 24'h0F0F0F, 0);
    bus.i_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.i_valid = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_valid", bus.o_valid, 0);
    chk("abort_ready", bus.o_ready, 1);
    chk("abort_product", bus.o_product, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NUM_PP + 4; i++) begin
      @(negedge clk);
      chk("abort_no_valid", bus.o_valid, 0);
    end

    run_op("post_rst", 24'h000005, 24'h000007, 0, 0, 1'b0, 1'b1, 48'd35);
    run_op("junk",     24'hABCDEF, 24'h13579B, 1, 2, 1'b1, 1'b0, '0);
    run_op("zero",     24'h000000, 24'hFFFFFF, 1, 0, 1'b0, 1'b1, 48'h0);
    run_op("ident",    24'hFFFFFF, 24'h000001, 1, 0, 1'b0, 1'b1, 48'h0000_00FF_FFFF);
    run_op("alt",      24'hAAAAAA, 24'h555555, 0, 1, 1'b0, 1'b0, '0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule
